// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator sequencer: FSM states,
// keypad codes, ALU op encodings and key classification helpers.
package calc_pkg;

    typedef enum logic [1:0] {
        ENTER_A,
        ENTER_B,
        EXEC,
        SHOW
    } state_t;

    localparam logic [3:0] KEY_ADD = 4'd10;
    localparam logic [3:0] KEY_SUB = 4'd11;
    localparam logic [3:0] KEY_MUL = 4'd12;
    localparam logic [3:0] KEY_DIV = 4'd13;
    localparam logic [3:0] KEY_EQ  = 4'd14;
    localparam logic [3:0] KEY_CLR = 4'd15;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;

    function automatic logic is_digit(input logic [3:0] key);
        return key <= 4'd9;
    endfunction

    function automatic logic is_op(input logic [3:0] key);
        return (key >= KEY_ADD) && (key <= KEY_DIV);
    endfunction

    function automatic logic [2:0] key_to_op(input logic [3:0] key);
        case (key)
            KEY_SUB: return OP_SUB;
            KEY_MUL: return OP_MUL;
            KEY_DIV: return OP_DIV;
            default: return OP_ADD;
        endcase
    endfunction

endpackage

// File: rtl/bcd_entry_reg.sv
// Four-digit BCD operand register: digits shift in at the low nibble,
// with synchronous clear/load and a four-significant-digit limit.
module bcd_entry_reg (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        shift,
    input  logic        load,
    input  logic [3:0]  digit,
    input  logic [15:0] load_val,
    output logic [15:0] q,
    output logic [15:0] nxt
);

    // nxt is exported so the controller can register the display in step
    always_comb begin
        nxt = q;
        if (clr) begin
            nxt = '0;
        end else if (load) begin
            nxt = load_val;
        end else if (shift && (q[15:12] == 4'd0)) begin
            nxt = {q[11:0], digit};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else begin
            q <= nxt;
        end
    end

endmodule

// File: rtl/calc_controller.sv
// Keypad-to-BCD-ALU sequencer with registered outputs.
// Define CALC_CHAIN_EN to let an operator key in SHOW chain from the result.
module calc_controller
    import calc_pkg::*;
#(
    parameter int unsigned ALU_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic [15:0] alu_num1,
    output logic [15:0] alu_num2,
    output logic [2:0]  alu_op,
    input  logic [15:0] alu_res,
    output logic [15:0] disp,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam logic [2:0] LAT_CNT = 3'(ALU_LAT);

    state_t      state, state_nxt;
    logic [2:0]  cnt, cnt_nxt;
    logic [15:0] res, res_nxt;
    logic [2:0]  op_nxt;
    logic [15:0] disp_nxt;
    logic        busy_nxt, done_nxt, err_nxt;

    logic        a_clr, a_shift, a_load;
    logic [15:0] a_load_val, a_nxt;
    logic        b_clr, b_shift;
    logic [15:0] b_nxt;

    bcd_entry_reg u_opa (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (a_clr),
        .shift    (a_shift),
        .load     (a_load),
        .digit    (key_code),
        .load_val (a_load_val),
        .q        (alu_num1),
        .nxt      (a_nxt)
    );

    bcd_entry_reg u_opb (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (b_clr),
        .shift    (b_shift),
        .load     (1'b0),
        .digit    (key_code),
        .load_val ('0),
        .q        (alu_num2),
        .nxt      (b_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ENTER_A;
            cnt    <= '0;
            res    <= '0;
            alu_op <= OP_ADD;
            disp   <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            res    <= res_nxt;
            alu_op <= op_nxt;
            disp   <= disp_nxt;
            busy   <= busy_nxt;
            done   <= done_nxt;
            err    <= err_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        res_nxt    = res;
        op_nxt     = alu_op;
        disp_nxt   = disp;
        busy_nxt   = 1'b0;
        done_nxt   = 1'b0;
        err_nxt    = err;
        a_clr      = 1'b0;
        a_shift    = 1'b0;
        a_load     = 1'b0;
        a_load_val = '0;
        b_clr      = 1'b0;
        b_shift    = 1'b0;

        if (state == EXEC) begin
            // keys are ignored entirely here; operands and op stay frozen
            if (cnt == '0) begin
                res_nxt   = alu_res;
                disp_nxt  = alu_res;
                done_nxt  = 1'b1;
                state_nxt = SHOW;
            end else begin
                cnt_nxt  = cnt - 3'd1;
                busy_nxt = 1'b1;
            end
        end else if (key_valid) begin
            if (key_code == KEY_CLR) begin
                a_clr     = 1'b1;
                b_clr     = 1'b1;
                op_nxt    = OP_ADD;
                res_nxt   = '0;
                cnt_nxt   = '0;
                disp_nxt  = '0;
                err_nxt   = 1'b0;
                state_nxt = ENTER_A;
            end else begin
                case (state)
                    ENTER_A: begin
                        if (is_digit(key_code)) begin
                            a_shift  = 1'b1;
                            disp_nxt = a_nxt;
                        end else if (is_op(key_code)) begin
                            op_nxt    = key_to_op(key_code);
                            b_clr     = 1'b1;
                            disp_nxt  = '0;
                            state_nxt = ENTER_B;
                        end
                    end
                    ENTER_B: begin
                        if (is_digit(key_code)) begin
                            b_shift  = 1'b1;
                            disp_nxt = b_nxt;
                        end else if (is_op(key_code)) begin
                            op_nxt = key_to_op(key_code);
                        end else if (key_code == KEY_EQ) begin
                            if ((alu_op == OP_DIV) && (alu_num2 == '0)) begin
                                res_nxt   = '0;
                                disp_nxt  = '0;
                                err_nxt   = 1'b1;
                                state_nxt = SHOW;
                            end else begin
                                cnt_nxt   = LAT_CNT;
                                busy_nxt  = 1'b1;
                                state_nxt = EXEC;
                            end
                        end
                    end
                    SHOW: begin
                        if (is_digit(key_code)) begin
                            a_load     = 1'b1;
                            a_load_val = {12'h000, key_code};
                            disp_nxt   = {12'h000, key_code};
                            state_nxt  = ENTER_A;
                        end else if (is_op(key_code)) begin
`ifdef CALC_CHAIN_EN
                            if (!err) begin
                                a_load     = 1'b1;
                                a_load_val = res;
                                op_nxt     = key_to_op(key_code);
                                b_clr      = 1'b1;
                                disp_nxt   = '0;
                                state_nxt  = ENTER_B;
                            end
`else
                            state_nxt = SHOW;
`endif
                        end
                    end
                    default: begin
                        state_nxt = state;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_calc_controller.sv
// Directed self-checking bench for calc_controller with a BCD ALU model,
// one instance at ALU_LAT=1 and one at ALU_LAT=3 sharing the keypad.
module tb_calc_controller;

    localparam int LAT1 = 1;
    localparam int LAT3 = 3;

    logic        clk;
    logic        rst_n;
    logic        key_valid;
    logic [3:0]  key_code;

    logic [15:0] n1_1, n2_1, disp_1, res_1;
    logic [2:0]  op_1;
    logic        busy_1, done_1, err_1;

    logic [15:0] n1_3, n2_3, disp_3, res_3;
    logic [2:0]  op_3;
    logic        busy_3, done_3, err_3;

    logic [15:0] pipe1 [0:6];
    logic [15:0] pipe3 [0:6];

    int total;
    int bad;

    calc_controller #(.ALU_LAT(LAT1)) dut1 (
        .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
        .alu_num1(n1_1), .alu_num2(n2_1), .alu_op(op_1), .alu_res(res_1),
        .disp(disp_1), .busy(busy_1), .done(done_1), .err(err_1)
    );

    calc_controller #(.ALU_LAT(LAT3)) dut3 (
        .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
        .alu_num1(n1_3), .alu_num2(n2_3), .alu_op(op_3), .alu_res(res_3),
        .disp(disp_3), .busy(busy_3), .done(done_3), .err(err_3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int bcd2i(input logic [15:0] b);
        return int'(b[15:12]) * 1000 + int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic logic [15:0] i2bcd(input int v);
        int w;
        w = v % 10000;
        if (w < 0) w = w + 10000;
        return {4'(w / 1000), 4'((w / 100) % 10), 4'((w / 10) % 10), 4'(w % 10)};
    endfunction

    function automatic logic [15:0] alu_f(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
        int x, y;
        x = bcd2i(a);
        y = bcd2i(b);
        case (op)
            3'b000:  return i2bcd(x + y);
            3'b001:  return i2bcd(x - y);
            3'b010:  return i2bcd(x * y);
            3'b011:  return (y == 0) ? 16'h0000 : i2bcd(x / y);
            default: return 16'h0000;
        endcase
    endfunction

    // ALU model: result of stable inputs appears after LAT rising edges
    always_ff @(posedge clk) begin
        pipe1[0] <= alu_f(n1_1, n2_1, op_1);
        pipe3[0] <= alu_f(n1_3, n2_3, op_3);
        for (int i = 1; i < 7; i++) begin
            pipe1[i] <= pipe1[i-1];
            pipe3[i] <= pipe3[i-1];
        end
    end
    assign res_1 = pipe1[LAT1-1];
    assign res_3 = pipe3[LAT3-1];

    task automatic press(input logic [3:0] k);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = k;
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = 4'd0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        key_valid = 1'b0;
        key_code = 4'd0;
        repeat (2) @(negedge clk);
        total++;
        if ({n1_1, n2_1, op_1, disp_1, busy_1, done_1, err_1} !== '0) begin
            bad++;
            $display("FAIL reset_lat1 got %h %h %b %h %b%b%b want all zero", n1_1, n2_1, op_1, disp_1, busy_1, done_1, err_1);
        end
        total++;
        if ({n1_3, n2_3, op_3, disp_3, busy_3, done_3, err_3} !== '0) begin
            bad++;
            $display("FAIL reset_lat3 got %h %h %b %h %b%b%b want all zero", n1_3, n2_3, op_3, disp_3, busy_3, done_3, err_3);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_add;
        int cyc;
        press(4'd1); press(4'd2);
        total++;
        if (disp_1 !== 16'h0012) begin bad++; $display("FAIL add_disp_a got %h want 0012", disp_1); end
        press(4'd10);
        total++;
        if (disp_1 !== 16'h0000) begin bad++; $display("FAIL add_disp_after_op got %h want 0000", disp_1); end
        press(4'd3); press(4'd4);
        total++;
        if ({n1_1, n2_1, op_1} !== {16'h0012, 16'h0034, 3'b000}) begin
            bad++; $display("FAIL add_operands got %h %h %b want 0012 0034 000", n1_1, n2_1, op_1);
        end
        press(4'd14);
        total++;
        if ({busy_1, done_1} !== 2'b10) begin bad++; $display("FAIL add_busy_start got %b%b want 10", busy_1, done_1); end
        cyc = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (done_1) begin cyc = i; break; end
        end
        total++;
        if (cyc !== 2) begin bad++; $display("FAIL add_done_latency got %0d want 2", cyc); end
        total++;
        if ({busy_1, disp_1} !== {1'b0, 16'h0046}) begin
            bad++; $display("FAIL add_result got busy=%b disp=%h want busy=0 disp=0046", busy_1, disp_1);
        end
        @(negedge clk);
        total++;
        if (done_1 !== 1'b0) begin bad++; $display("FAIL add_done_pulse got %b want 0", done_1); end
        idle(6);
    endtask

    task automatic test_digit_entry;
        press(4'd15);
        press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'd5);
        total++;
        if ({disp_1, n1_1} !== {16'h1234, 16'h1234}) begin bad++; $display("FAIL fifth_digit got %h %h want 1234 1234", disp_1, n1_1); end
        press(4'd15);
        press(4'd0); press(4'd0); press(4'd7);
        total++;
        if (disp_1 !== 16'h0007) begin bad++; $display("FAIL leading_zero_short got %h want 0007", disp_1); end
        press(4'd15);
        press(4'd0); press(4'd0); press(4'd0); press(4'd0);
        press(4'd1); press(4'd2); press(4'd3); press(4'd4);
        total++;
        if (disp_1 !== 16'h1234) begin bad++; $display("FAIL leading_zero_limit got %h want 1234", disp_1); end
        press(4'd14);
        idle(3);
        total++;
        if ({busy_1, done_1, disp_1} !== {2'b00, 16'h1234}) begin
            bad++; $display("FAIL eq_in_enter_a got %b%b %h want 00 1234", busy_1, done_1, disp_1);
        end
        @(negedge clk);
        key_valid = 1'b0;
        key_code = 4'd3;
        @(negedge clk);
        key_code = 4'd0;
        total++;
        if (disp_1 !== 16'h1234) begin bad++; $display("FAIL invalid_key got %h want 1234", disp_1); end
    endtask

    task automatic test_div_zero;
        int seen;
        press(4'd15);
        press(4'd9); press(4'd13); press(4'd0); press(4'd14);
        total++;
        if ({err_1, busy_1, disp_1} !== {2'b10, 16'h0000}) begin
            bad++; $display("FAIL div0_state got err=%b busy=%b disp=%h want 1 0 0000", err_1, busy_1, disp_1);
        end
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done_1) seen = 1;
        end
        total++;
        if (seen !== 0) begin bad++; $display("FAIL div0_no_done got %0d want 0", seen); end
        press(4'd15);
        total++;
        if ({err_1, disp_1} !== {1'b0, 16'h0000}) begin bad++; $display("FAIL div0_clear got err=%b disp=%h want 0 0000", err_1, disp_1); end
        press(4'd5);
        total++;
        if ({disp_1, n1_1} !== {16'h0005, 16'h0005}) begin bad++; $display("FAIL div0_back_to_a got %h %h want 0005 0005", disp_1, n1_1); end
    endtask

    task automatic test_busy_drop;
        press(4'd15);
        press(4'd2); press(4'd12); press(4'd3);
        @(negedge clk);
        key_valid = 1'b1;
        key_code = 4'd14;
        @(negedge clk);
        total++;
        if (busy_1 !== 1'b1) begin bad++; $display("FAIL drop_busy got %b want 1", busy_1); end
        key_code = 4'd15;
        @(negedge clk);
        total++;
        if ({n1_1, n2_1, op_1, disp_1, err_1} !== {16'h0002, 16'h0003, 3'b010, 16'h0003, 1'b0}) begin
            bad++; $display("FAIL drop_clear got %h %h %b %h %b want 0002 0003 010 0003 0", n1_1, n2_1, op_1, disp_1, err_1);
        end
        key_code = 4'd7;
        @(negedge clk);
        key_valid = 1'b0;
        key_code = 4'd0;
        total++;
        if ({done_1, disp_1, n1_1} !== {1'b1, 16'h0006, 16'h0002}) begin
            bad++; $display("FAIL drop_digit got done=%b disp=%h a=%h want 1 0006 0002", done_1, disp_1, n1_1);
        end
        idle(6);
    endtask

    task automatic test_reset_exec;
        int seen;
        press(4'd15);
        press(4'd1); press(4'd10); press(4'd1); press(4'd14);
        total++;
        if ({busy_1, busy_3} !== 2'b11) begin bad++; $display("FAIL rexec_busy got %b%b want 11", busy_1, busy_3); end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({n1_1, n2_1, op_1, disp_1, busy_1, done_1, err_1} !== '0) begin
            bad++; $display("FAIL rexec_outputs got %h %h %b %h %b%b%b want all zero", n1_1, n2_1, op_1, disp_1, busy_1, done_1, err_1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done_1 || done_3 || (disp_1 != 16'h0000)) seen = 1;
        end
        total++;
        if (seen !== 0) begin bad++; $display("FAIL rexec_discard got %0d want 0", seen); end
    endtask

    task automatic test_chain;
        press(4'd15);
        press(4'd2); press(4'd10); press(4'd3); press(4'd14);
        idle(8);
        total++;
        if (disp_1 !== 16'h0005) begin bad++; $display("FAIL chain_first got %h want 0005", disp_1); end
        press(4'd12);
`ifdef CALC_CHAIN_EN
        total++;
        if ({disp_1, n1_1, op_1} !== {16'h0000, 16'h0005, 3'b010}) begin
            bad++; $display("FAIL chain_op got %h %h %b want 0000 0005 010", disp_1, n1_1, op_1);
        end
        press(4'd4); press(4'd14);
        idle(8);
        total++;
        if (disp_1 !== 16'h0020) begin bad++; $display("FAIL chain_result got %h want 0020", disp_1); end
`else
        total++;
        if ({disp_1, n1_1, op_1} !== {16'h0005, 16'h0002, 3'b000}) begin
            bad++; $display("FAIL chain_ignored got %h %h %b want 0005 0002 000", disp_1, n1_1, op_1);
        end
        press(4'd4);
        total++;
        if ({disp_1, n1_1} !== {16'h0004, 16'h0004}) begin bad++; $display("FAIL show_digit got %h %h want 0004 0004", disp_1, n1_1); end
`endif
    endtask

    task automatic test_lat3;
        int cnt;
        press(4'd15);
        press(4'd6); press(4'd12); press(4'd7); press(4'd14);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (!busy_3) break;
            cnt++;
            @(negedge clk);
        end
        total++;
        if (cnt !== 4) begin bad++; $display("FAIL lat3_busy_cycles got %0d want 4", cnt); end
        total++;
        if ({done_3, disp_3} !== {1'b1, 16'h0042}) begin
            bad++; $display("FAIL lat3_result got done=%b disp=%h want 1 0042", done_3, disp_3);
        end
        @(negedge clk);
        total++;
        if (done_3 !== 1'b0) begin bad++; $display("FAIL lat3_done_pulse got %b want 0", done_3); end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset;
        test_add;
        test_digit_entry;
        test_div_zero;
        test_busy_drop;
        test_reset_exec;
        test_chain;
        test_lat3;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/calc_controller.md
# calc_controller

Sequencer for the calculator's BCD ALU. Collects keypad digits into two 4-digit BCD operands, latches the operator, and drives the ALU's operand and op inputs. It waits out the ALU's registered latency, then captures the BCD result for the display. It sits between the keypad decoder and the ALU/seven-segment display path.

## Interface
- `ALU_LAT`, default 1: clock edges from stable ALU inputs to a valid ALU `res`. Legal range is 1–7.
- `clk` input 1: system clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `key_valid` input 1: one-cycle strobe; `key_code` is valid in the same cycle.
- `key_code` input 4: 0–9 digit, 10 add, 11 sub, 12 mul, 13 div, 14 equals, 15 clear.
- `alu_num1` output 16: BCD operand A to the ALU.
- `alu_num2` output 16: BCD operand B to the ALU.
- `alu_op` output 3: ALU op, where 000 add, 001 sub, 010 mul, 011 div.
- `alu_res` input 16: BCD result from the ALU.
- `disp` output 16: BCD value to display.
- `busy` output 1: high while in EXEC; keys are dropped while high.
- `done` output 1: one-cycle pulse when a result is captured.
- `err` output 1: sticky error flag; only clear or reset drops it.

## Operation
- States:
  - ENTER_A: building operand A.
  - ENTER_B: building operand B.
  - EXEC: waiting on the ALU.
  - SHOW: holding the result.
- Digit entry: new digit shifts in at `[3:0]`, the others shift left one nibble. A fifth digit is ignored while the top nibble is nonzero. Leading zeros do not count toward the limit.
- `disp` follows the operand currently being entered.
- ENTER_A + operator key: latch `alu_op`, clear B, go to ENTER_B.
- ENTER_A + equals: ignored.
- ENTER_B + operator key: replace `alu_op`, B is unchanged.
- ENTER_B + equals with div and B == 0:
  - go to SHOW, `disp`=0, `err`=1.
  - EXEC is skipped and no `done` pulse is issued.
- ENTER_B + equals, all other cases: go to EXEC and load the wait counter with `ALU_LAT`.
- EXEC:
  - `alu_num1`, `alu_num2` and `alu_op` are held constant.
  - Counter decrements each cycle. At 0, capture `alu_res` into the result register, pulse `done`, go to SHOW.
- SHOW:
  - `disp` = result.
  - Digit key: A = that digit, go to ENTER_A.
  - Equals: ignored.
  - Operator key: see Configuration.
- Clear (15), any state except EXEC: all registers to reset values, go to ENTER_A.
- Every key during EXEC is dropped, clear included. Nothing is queued.
- Any `key_code` value with `key_valid` low is ignored.
- Sub results that would be negative, and results above 9999, are whatever the ALU produces. The controller does not check them.

## Timing
- Reset values:
  - state ENTER_A
  - `alu_num1`, `alu_num2`, `disp` = 16'h0000
  - `alu_op` = 3'b000
  - `busy`, `done`, `err` = 0
- All outputs are registered.
- Key accepted at edge N: the updated operand is visible on `disp` after edge N.
- Equals accepted at edge N:
  - `busy`=1 from after edge N.
  - `alu_res` is sampled at edge N+`ALU_LAT`+1.
  - After that same edge: `busy`=0, `done`=1 for exactly one cycle, `disp` = result.
- Worst-case key-to-key throughput in EXEC is `ALU_LAT`+2 cycles.
- `rst_n` asserted mid-EXEC: outputs go to reset values immediately. Any ALU result still in flight is discarded.

## Configuration
- `CALC_CHAIN_EN` defined:
  - Operator key in SHOW: A = result, latch `alu_op`, clear B, go to ENTER_B. This allows "2+3=×4=" → 20.
  - If `err`=1, the operator key is ignored.
- `CALC_CHAIN_EN` undefined:
  - Operator key in SHOW is ignored. Only a digit or clear leaves SHOW.

## Structure
- Package `calc_pkg` holds:
  - the state enum type
  - key-code constants (`KEY_ADD` … `KEY_CLR`)
  - ALU op constants (`OP_ADD` … `OP_DIV`)
  - a function mapping operator key to op code
- One sub-module, `bcd_entry_reg`: 4-digit BCD shift-in register with clear, load and digit-count limit. It is instantiated twice, for A and B.
- The FSM, wait counter and result register live in `calc_controller`.

## Test plan
- Reset then keys 1,2,+,3,4,= → `alu_num1`=16'h0012, `alu_num2`=16'h0034, `alu_op`=000. With the ALU model, `done` pulses at edge N+`ALU_LAT`+1 and `disp`=16'h0046.
- Keys 1,2,3,4,5 → `disp`=16'h1234. Then 0,0,7 after a clear → `disp`=16'h0007.
- Keys 9,/,0,= → `err`=1, `disp`=0, no `done` pulse. Then clear → `err`=0, state ENTER_A.
- Keys sent while `busy`=1 → no state or operand change. `rst_n` low mid-EXEC → every output is 0 on the same cycle.
- With `CALC_CHAIN_EN`: 2,+,3,=,×,4,= → `disp`=16'h0020.
- Without `CALC_CHAIN_EN`: the × key stays in SHOW with `disp`=16'h0005.
- `ALU_LAT`=3 with keys 6,×,7,= → `busy` high exactly 4 cycles, `disp`=16'h0042.
